// File: rtl/ks_pkg.sv
// Shared types and constants for the pipelined Kogge-Stone adder.
package ks_pkg;

  localparam int KS_WIDTH_DEFAULT = 16;

  // One propagate/generate pair; a P/G vector is ks_pg_t [WIDTH-1:0].
  typedef struct packed {
    logic g;
    logic p;
  } ks_pg_t;

  // Number of prefix levels for a power-of-two operand width.
  function automatic int ks_log2(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: merges a higher P/G group with a lower one.
module ks_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder: one register bank for the bitwise P/G stage
// and one per prefix level, valid/ready handshake with full backpressure.
module ks_pipe_adder
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int LOG2W = ks_log2(WIDTH);
  localparam int LAT   = LOG2W + 1;

  // Stage registers: group P/G, original p and cin carried alongside.
  ks_pg_t [WIDTH-1:0] pg_q [LAT];
  ks_pg_t [WIDTH-1:0] pg_d [LAT];
  logic   [WIDTH-1:0] p_q  [LAT];
  logic   [WIDTH-1:0] p_d  [LAT];
  logic   [LAT-1:0]   valid_q, valid_d;
  logic   [LAT-1:0]   cin_q, cin_d;

  // Value each stage would load when it is allowed to advance.
  wire ks_pg_t [WIDTH-1:0] pg_src [LAT];
  wire         [WIDTH-1:0] p_src  [LAT];
  wire         [LAT-1:0]   valid_src;
  wire         [LAT-1:0]   cin_src;

  ks_pg_t [WIDTH-1:0] s0_pg;
  logic   [LAT:0]     rdy;

  // Bitwise P/G from the operands, with cin folded into bit 0's generate.
  always_comb begin
    s0_pg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s0_pg[i].p = a[i] ^ b[i];
      s0_pg[i].g = a[i] & b[i];
    end
    s0_pg[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign pg_src[k]    = s0_pg;
      assign p_src[k]     = a ^ b;
      assign valid_src[k] = in_valid;
      assign cin_src[k]   = cin;
    end else begin : g_lvl
      localparam int D = 1 << (k - 1);
      assign p_src[k]     = p_q[k-1];
      assign valid_src[k] = valid_q[k-1];
      assign cin_src[k]   = cin_q[k-1];
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_cell
          ks_prefix_cell u_cell (
            .g_hi  (pg_q[k-1][i].g),
            .p_hi  (pg_q[k-1][i].p),
            .g_lo  (pg_q[k-1][i-D].g),
            .p_lo  (pg_q[k-1][i-D].p),
            .g_out (pg_src[k][i].g),
            .p_out (pg_src[k][i].p)
          );
        end else begin : g_pass
          assign pg_src[k][i] = pg_q[k-1][i];
        end
      end
    end
  end

  // Ready chain: a stage can advance if it is empty or the next one advances.
  always_comb begin
    rdy      = '0;
    rdy[LAT] = out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      rdy[k] = ~valid_q[k] | rdy[k+1];
    end
  end

  // Next-state: a stage loads from upstream when ready, otherwise holds.
  always_comb begin
    valid_d = valid_q;
    cin_d   = cin_q;
    pg_d    = pg_q;
    p_d     = p_q;
    for (int k = 0; k < LAT; k++) begin
      if (rdy[k]) begin
        valid_d[k] = valid_src[k];
        cin_d[k]   = cin_src[k];
        pg_d[k]    = pg_src[k];
        p_d[k]     = p_src[k];
      end
    end
  end

  // Stage register banks; reset discards every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cin_q   <= '0;
      for (int k = 0; k < LAT; k++) begin
        pg_q[k] <= '0;
        p_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cin_q   <= cin_d;
      pg_q    <= pg_d;
      p_q     <= p_d;
    end
  end

  logic [WIDTH-1:0] top_g;
  logic [WIDTH-1:0] top_p;
  logic [WIDTH-1:0] carry;
  logic             unused_top_p;

  // Sum and carry-out purely from the last stage's registers.
  always_comb begin
    top_g = '0;
    top_p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      top_g[i] = pg_q[LAT-1][i].g;
      top_p[i] = pg_q[LAT-1][i].p;
    end
    carry        = {top_g[WIDTH-2:0], cin_q[LAT-1]};
    sum          = p_q[LAT-1] ^ carry;
    cout         = top_g[WIDTH-1];
    unused_top_p = ^top_p;
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[LAT-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Directed and randomized checks for ks_pipe_adder at WIDTH=16.
module tb_ks_pipe_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  wire              in_ready;
  wire              out_valid;
  wire              cout;
  wire              busy;
  wire  [WIDTH-1:0] sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ks_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int sent;
    int cyc;
    logic [16:0] e;
    logic [16:0] q[$];

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    #5 rst_n = 1'b1;
    tick;

    // Single accept: 0xFFFF + 0x0001 wraps to 0 with carry-out
    out_ready = 1'b1;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin tick; n++; end
    chk("t1_latency", 32'(n), 5);
    chk("t1_sum", 32'(sum), 32'h0000);
    chk("t1_cout", 32'(cout), 1);
    tick;
    chk("t1_one_beat", 32'(out_valid), 0);

    // Back-to-back: carry ripple through cin, then a plain add
    a = 16'h7FFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
    tick;
    a = 16'h1234; b = 16'h4321; cin = 1'b0;
    tick;
    in_valid = 1'b0;
    n = 2;
    while (!out_valid && n < 40) begin tick; n++; end
    chk("t2_latency", 32'(n), 5);
    chk("t2_sum0", 32'(sum), 32'h8000);
    chk("t2_cout0", 32'(cout), 0);
    tick;
    chk("t2_valid1", 32'(out_valid), 1);
    chk("t2_sum1", 32'(sum), 32'h5555);
    chk("t2_cout1", 32'(cout), 0);
    tick;
    chk("t2_drained", 32'(out_valid), 0);

    // Backpressure: capacity is exactly 5 entries
    out_ready = 1'b0; in_valid = 1'b1; b = 16'h0001; cin = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      a = 16'(acc);
      #1;
      if (in_ready) acc++;
      tick;
    end
    chk("t3_accepts", 32'(acc), 5);
    chk("t3_full_ready", 32'(in_ready), 0);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_out_valid", 32'(out_valid), 1);
    chk("t3_head_sum", 32'(sum), 32'h0001);
    tick;
    chk("t3_stall_sum", 32'(sum), 32'h0001);
    chk("t3_stall_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t3_ready_same_cycle", 32'(in_ready), 1);
    for (int j = 0; j < 5; j++) begin
      chk("t3_pop_valid", 32'(out_valid), 1);
      chk("t3_pop_sum", 32'(sum), 32'(j + 1));
      tick;
    end
    chk("t3_empty_valid", 32'(out_valid), 0);
    chk("t3_empty_busy", 32'(busy), 0);

    // Full pipe streaming: one in, one out per cycle, no bubble
    q.delete();
    out_ready = 1'b0; in_valid = 1'b1; b = 16'h00F0; cin = 1'b0;
    for (int j = 0; j < 5; j++) begin
      a = 16'(16'h0100 + j);
      q.push_back({1'b0, a} + {1'b0, b});
      tick;
    end
    chk("t4_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a = 16'(16'h0105 + c);
      #1;
      chk("t4_in_ready", 32'(in_ready), 1);
      chk("t4_out_valid", 32'(out_valid), 1);
      chk("t4_busy", 32'(busy), 1);
      chk("t4_result", 32'({cout, sum}), 32'(q.pop_front()));
      q.push_back({1'b0, a} + {1'b0, b});
      tick;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("t4_drain_valid", 32'(out_valid), 1);
      chk("t4_drain_result", 32'({cout, sum}), 32'(q.pop_front()));
      tick;
    end
    chk("t4_drain_busy", 32'(busy), 0);

    // Asynchronous reset with three entries in flight
    out_ready = 1'b1; in_valid = 1'b1; b = 16'h0001; cin = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = 16'(16'h0AA0 + j);
      tick;
    end
    in_valid = 1'b0;
    chk("t5_busy_before", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_sum", 32'(sum), 0);
    chk("t5_rst_cout", 32'(cout), 0);
    #1 rst_n = 1'b1;
    a = 16'h00FF; b = 16'h0F01; cin = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin tick; n++; end
    chk("t5_latency", 32'(n), 5);
    chk("t5_sum", 32'(sum), 32'h1001);
    chk("t5_cout", 32'(cout), 0);
    tick;

    // Random operands with random valid/ready against an in-order scoreboard
    q.delete();
    sent = 0;
    cyc = 0;
    while ((sent < 10000 || q.size() > 0) && cyc < 30000) begin
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(1));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        assert (q.size() != 0) else begin
          failures++;
          $error("FAIL rnd_spurious observed=result expected=none");
        end
        if (q.size() != 0) chk("rnd_result", 32'({cout, sum}), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        e = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        q.push_back(e);
        sent++;
      end
      tick;
      cyc++;
    end
    chk("rnd_sent", 32'(sent), 10000);
    chk("rnd_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
